// File: rtl/pipeline_ctl_seq.sv
// Registered ID->ID/EX control decoder with bubble insertion and a HALT drain sequencer.
// Latency: 1 cycle from ID-stage inputs to the registered EX control bundle.
// Backpressure: stall/flush load a bubble; fetch_hold freezes fetch from HALT acceptance onwards.
// Option macro PIPELINE_CTL_ILLEGAL_TRAP_EN: unknown opcodes raise sticky `illegal` instead of halting.
module pipeline_ctl_seq #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 32,
   parameter logic [6:0]  HALT_OPCODE  = 7'h7F
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             stall,
   input  logic             flush,
   output logic             ex_valid,
   output logic             alu_src,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             branch,
   output logic             branch_ne,
   output logic [2:0]       alu_operation,
   output logic             fetch_hold,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] issued_cnt
);

   // alu module operation encodings
   localparam logic [2:0] ADD_64  = 3'd0;
   localparam logic [2:0] SUB_64  = 3'd1;
   localparam logic [2:0] BIT_AND = 3'd2;
   localparam logic [2:0] BIT_OR  = 3'd3;
   localparam logic [2:0] BIT_XOR = 3'd4;
   localparam logic [2:0] ALU_NOP = 3'd7;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_NOP    = 7'b0000000;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   logic [1:0] state;
   logic [3:0] drain_cnt;

   logic       dec_ex_valid;
   logic       dec_alu_src;
   logic       dec_mem_to_reg;
   logic       dec_reg_write;
   logic       dec_mem_read;
   logic       dec_mem_write;
   logic       dec_branch;
   logic       dec_branch_ne;
   logic [2:0] dec_alu_op;
   logic       dec_halt;
   logic       dec_unknown;

   logic       accept;
   logic       go_halt;

   assign accept = id_valid & ~stall & ~flush & (state == ST_RUN);

`ifdef PIPELINE_CTL_ILLEGAL_TRAP_EN
   assign go_halt = dec_halt;
`else
   // Legacy behaviour: anything we cannot decode stops the machine.
   assign go_halt = dec_halt | dec_unknown;
`endif

   assign fetch_hold = (state != ST_RUN);
   assign halted     = (state == ST_HALTED);

   // Combinational decode of the ID instruction; defaults describe a bubble.
   always_comb begin
      dec_ex_valid   = 1'b0;
      dec_alu_src    = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_reg_write  = 1'b0;
      dec_mem_read   = 1'b0;
      dec_mem_write  = 1'b0;
      dec_branch     = 1'b0;
      dec_branch_ne  = 1'b0;
      dec_alu_op     = ALU_NOP;
      dec_halt       = 1'b0;
      dec_unknown    = 1'b0;
      case (opcode)
         OP_R: begin
            dec_ex_valid  = 1'b1;
            dec_reg_write = 1'b1;
            if (funct3 == 3'b000 && funct7 == 7'h00)      dec_alu_op = ADD_64;
            else if (funct3 == 3'b000 && funct7 == 7'h20) dec_alu_op = SUB_64;
            else if (funct3 == 3'b111 && funct7 == 7'h00) dec_alu_op = BIT_AND;
            else if (funct3 == 3'b110 && funct7 == 7'h00) dec_alu_op = BIT_OR;
            else if (funct3 == 3'b100 && funct7 == 7'h00) dec_alu_op = BIT_XOR;
            else                                          dec_reg_write = 1'b0;
         end
         OP_I: begin
            dec_ex_valid  = 1'b1;
            dec_alu_src   = 1'b1;
            dec_reg_write = 1'b1;
            case (funct3)
               3'b000:  dec_alu_op = ADD_64;
               3'b111:  dec_alu_op = BIT_AND;
               3'b110:  dec_alu_op = BIT_OR;
               3'b100:  dec_alu_op = BIT_XOR;
               default: dec_reg_write = 1'b0;
            endcase
         end
         OP_LOAD: begin
            dec_ex_valid   = 1'b1;
            dec_alu_src    = 1'b1;
            dec_mem_to_reg = 1'b1;
            dec_reg_write  = 1'b1;
            dec_mem_read   = 1'b1;
            dec_alu_op     = ADD_64;
         end
         OP_STORE: begin
            dec_ex_valid  = 1'b1;
            dec_alu_src   = 1'b1;
            dec_mem_write = 1'b1;
            dec_alu_op    = ADD_64;
         end
         OP_BRANCH: begin
            // Unsupported branch conditions stay a bubble.
            if (funct3 == 3'b000) begin
               dec_ex_valid = 1'b1;
               dec_branch   = 1'b1;
               dec_alu_op   = SUB_64;
            end else if (funct3 == 3'b001) begin
               dec_ex_valid  = 1'b1;
               dec_branch_ne = 1'b1;
               dec_alu_op    = SUB_64;
            end
         end
         OP_NOP: begin
            dec_ex_valid = 1'b1;
         end
         HALT_OPCODE: begin
            dec_halt = 1'b1;
         end
         default: begin
            dec_unknown = 1'b1;
         end
      endcase
   end

   // ID/EX control bundle: decoded values when accepted, otherwise a bubble.
   always_ff @(posedge clk) begin
      if (reset || !accept) begin
         ex_valid      <= 1'b0;
         alu_src       <= 1'b0;
         mem_to_reg    <= 1'b0;
         reg_write     <= 1'b0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         branch        <= 1'b0;
         branch_ne     <= 1'b0;
         alu_operation <= ALU_NOP;
      end else begin
         ex_valid      <= dec_ex_valid;
         alu_src       <= dec_alu_src;
         mem_to_reg    <= dec_mem_to_reg;
         reg_write     <= dec_reg_write;
         mem_read      <= dec_mem_read;
         mem_write     <= dec_mem_write;
         branch        <= dec_branch;
         branch_ne     <= dec_branch_ne;
         alu_operation <= dec_alu_op;
      end
   end

   // Halt sequencer: RUN -> DRAIN (count down) -> HALTED, absorbing until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_RUN;
         drain_cnt <= 4'd0;
      end else begin
         case (state)
            ST_RUN: begin
               if (accept && go_halt) begin
                  drain_cnt <= DRAIN_LOAD;
                  state     <= (DRAIN_LOAD == 4'd0) ? ST_HALTED : ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               drain_cnt <= drain_cnt - 4'd1;
               if (drain_cnt <= 4'd1) state <= ST_HALTED;
            end
            ST_HALTED: state <= ST_HALTED;
            default:   state <= ST_RUN;
         endcase
      end
   end

   // Saturating count of real (non-bubble) bundles loaded into ID/EX.
   always_ff @(posedge clk) begin
      if (reset) begin
         issued_cnt <= '0;
      end else if (accept && dec_ex_valid && issued_cnt != CNT_MAX) begin
         issued_cnt <= issued_cnt + CNT_W'(1);
      end
   end

`ifdef PIPELINE_CTL_ILLEGAL_TRAP_EN
   // Sticky flag for any accepted opcode the decoder does not know.
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal <= 1'b0;
      end else if (accept && dec_unknown) begin
         illegal <= 1'b1;
      end
   end
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctl_seq.sv
// Bench for pipeline_ctl_seq: directed vector table, hand-written halt/reset sequences, random run vs. model.
// Two instances share stimulus: default parameters, and DRAIN_CYCLES=0 / CNT_W=4.
// Build with PIPELINE_CTL_ILLEGAL_TRAP_EN defined to exercise the trap variant.
module tb_pipeline_ctl_seq;

   localparam logic [2:0] A_ADD = 3'd0;
   localparam logic [2:0] A_SUB = 3'd1;
   localparam logic [2:0] A_AND = 3'd2;
   localparam logic [2:0] A_OR  = 3'd3;
   localparam logic [2:0] A_XOR = 3'd4;
   localparam logic [2:0] A_NOP = 3'd7;
   localparam logic [6:0] HALT  = 7'h7F;
   localparam int DRAIN1 = 3;
   localparam int DRAIN2 = 0;
   localparam longint MAX1 = 64'hFFFF_FFFF;
   localparam longint MAX2 = 15;
   localparam int K_NORMAL = 0;
   localparam int K_HALT   = 1;
   localparam int K_UNK    = 2;
`ifdef PIPELINE_CTL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct packed {
      logic       ex_valid;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       branch_ne;
      logic [2:0] alu;
   } bundle_t;

   localparam bundle_t BUBBLE = {8'b0, 3'd7};

   typedef struct {
      logic       rst, iv, st, fl;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      bundle_t    b;
      int         cnt;
      logic       fh, h;
   } vec_t;

   logic clk = 1'b0;
   logic reset, id_valid, stall, flush;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;

   logic ex_valid, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, branch_ne;
   logic [2:0] alu_operation;
   logic fetch_hold, halted, illegal;
   logic [31:0] issued_cnt;

   logic ex_valid2, alu_src2, mem_to_reg2, reg_write2, mem_read2, mem_write2, branch2, branch_ne2;
   logic [2:0] alu_operation2;
   logic fetch_hold2, halted2, illegal2;
   logic [3:0] issued_cnt2;

   bundle_t act1, act2;
   assign act1 = {ex_valid, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, branch_ne, alu_operation};
   assign act2 = {ex_valid2, alu_src2, mem_to_reg2, reg_write2, mem_read2, mem_write2, branch2, branch_ne2, alu_operation2};

   int vectors = 0;
   int errors  = 0;

   // reference model state: cd < 0 running, cd > 0 draining, cd == 0 halted
   int      cd1, cd2;
   longint  cnt1, cnt2;
   bit      ill_m;
   bundle_t exp_b;

   vec_t tbl[$];

   always #5 clk = ~clk;

   pipeline_ctl_seq dut1 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
      .funct7(funct7), .stall(stall), .flush(flush), .ex_valid(ex_valid), .alu_src(alu_src),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .branch_ne(branch_ne), .alu_operation(alu_operation),
      .fetch_hold(fetch_hold), .halted(halted), .illegal(illegal), .issued_cnt(issued_cnt)
   );

   pipeline_ctl_seq #(.DRAIN_CYCLES(0), .CNT_W(4)) dut2 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
      .funct7(funct7), .stall(stall), .flush(flush), .ex_valid(ex_valid2), .alu_src(alu_src2),
      .mem_to_reg(mem_to_reg2), .reg_write(reg_write2), .mem_read(mem_read2), .mem_write(mem_write2),
      .branch(branch2), .branch_ne(branch_ne2), .alu_operation(alu_operation2),
      .fetch_hold(fetch_hold2), .halted(halted2), .illegal(illegal2), .issued_cnt(issued_cnt2)
   );

   function automatic bundle_t mk(input logic ev, asrc, m2r, rw, mr, mw, br, bne, input logic [2:0] a);
      mk = {ev, asrc, m2r, rw, mr, mw, br, bne, a};
   endfunction

   // Instruction semantics written per mnemonic.
   function automatic bundle_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, output int kind);
      logic [2:0] a;
      bundle_t b;
      kind = K_NORMAL;
      b = BUBBLE;
      a = A_NOP;
      if (op == 7'h33) begin
         if (f3 == 3'd0 && f7 == 7'h00) a = A_ADD;
         else if (f3 == 3'd0 && f7 == 7'h20) a = A_SUB;
         else if (f7 == 7'h00 && f3 == 3'd7) a = A_AND;
         else if (f7 == 7'h00 && f3 == 3'd6) a = A_OR;
         else if (f7 == 7'h00 && f3 == 3'd4) a = A_XOR;
         b = mk(1, 0, 0, a != A_NOP, 0, 0, 0, 0, a);
      end else if (op == 7'h13) begin
         if (f3 == 3'd0) a = A_ADD;
         else if (f3 == 3'd7) a = A_AND;
         else if (f3 == 3'd6) a = A_OR;
         else if (f3 == 3'd4) a = A_XOR;
         b = mk(1, 1, 0, a != A_NOP, 0, 0, 0, 0, a);
      end else if (op == 7'h03) b = mk(1, 1, 1, 1, 1, 0, 0, 0, A_ADD);
      else if (op == 7'h23) b = mk(1, 1, 0, 0, 0, 1, 0, 0, A_ADD);
      else if (op == 7'h63) begin
         if (f3 == 3'd0) b = mk(1, 0, 0, 0, 0, 0, 1, 0, A_SUB);
         else if (f3 == 3'd1) b = mk(1, 0, 0, 0, 0, 0, 0, 1, A_SUB);
      end else if (op == 7'h00) b = mk(1, 0, 0, 0, 0, 0, 0, 0, A_NOP);
      else if (op == HALT) kind = K_HALT;
      else kind = K_UNK;
      return b;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      bundle_t d;
      int kind;
      bit acc;
      d = ref_decode(opcode, funct3, funct7, kind);
      if (reset) begin
         exp_b = BUBBLE; cd1 = -1; cd2 = -1; cnt1 = 0; cnt2 = 0; ill_m = 1'b0;
         return;
      end
      acc = (cd1 < 0) && id_valid && !stall && !flush;
      if (cd1 > 0) cd1--;
      if (cd2 > 0) cd2--;
      exp_b = BUBBLE;
      if (acc) begin
         if (kind == K_HALT || (kind == K_UNK && !TRAP)) begin
            cd1 = DRAIN1;
            cd2 = DRAIN2;
         end else if (kind == K_UNK) begin
            ill_m = 1'b1;
         end else begin
            exp_b = d;
            if (d.ex_valid) begin
               if (cnt1 < MAX1) cnt1++;
               if (cnt2 < MAX2) cnt2++;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic drive(input logic r, iv, st, fl, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7);
      reset = r; id_valid = iv; stall = st; flush = fl;
      opcode = op; funct3 = f3; funct7 = f7;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_bundle"}, 64'(act1), 64'(exp_b));
      check({tag, "_bundle2"}, 64'(act2), 64'(exp_b));
      check({tag, "_fetch_hold"}, 64'(fetch_hold), 64'(cd1 >= 0));
      check({tag, "_halted"}, 64'(halted), 64'(cd1 == 0));
      check({tag, "_fetch_hold2"}, 64'(fetch_hold2), 64'(cd2 >= 0));
      check({tag, "_halted2"}, 64'(halted2), 64'(cd2 == 0));
      check({tag, "_illegal"}, 64'(illegal), 64'(ill_m));
      check({tag, "_illegal2"}, 64'(illegal2), 64'(ill_m));
      check({tag, "_cnt"}, 64'(issued_cnt), 64'(cnt1));
      check({tag, "_cnt2"}, 64'(issued_cnt2), 64'(cnt2));
   endtask

   task automatic add_vec(input logic r, iv, st, fl, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input bundle_t b, input int c, input logic fh, h);
      vec_t v;
      v.rst = r; v.iv = iv; v.st = st; v.fl = fl; v.op = op; v.f3 = f3; v.f7 = f7;
      v.b = b; v.cnt = c; v.fh = fh; v.h = h;
      tbl.push_back(v);
   endtask

   initial begin
      drive(1, 0, 0, 0, 7'h00, 3'd0, 7'h00);

      // rst iv st fl  op     f3  f7      expected bundle                           cnt fh h
      add_vec(1, 0, 0, 0, 7'h00, 3'd0, 7'h00, BUBBLE,                             0, 0, 0);
      add_vec(0, 1, 0, 0, 7'h33, 3'd0, 7'h00, mk(1, 0, 0, 1, 0, 0, 0, 0, A_ADD), 1, 0, 0);
      add_vec(0, 1, 1, 0, 7'h33, 3'd0, 7'h20, BUBBLE,                             1, 0, 0);
      add_vec(0, 1, 0, 0, 7'h33, 3'd0, 7'h20, mk(1, 0, 0, 1, 0, 0, 0, 0, A_SUB), 2, 0, 0);
      add_vec(0, 1, 0, 0, 7'h63, 3'd1, 7'h00, mk(1, 0, 0, 0, 0, 0, 0, 1, A_SUB), 3, 0, 0);
      add_vec(0, 1, 0, 0, 7'h63, 3'd0, 7'h00, mk(1, 0, 0, 0, 0, 0, 1, 0, A_SUB), 4, 0, 0);
      add_vec(0, 1, 0, 1, HALT,  3'd0, 7'h00, BUBBLE,                             4, 0, 0);
      add_vec(0, 1, 0, 0, 7'h03, 3'd3, 7'h00, mk(1, 1, 1, 1, 1, 0, 0, 0, A_ADD), 5, 0, 0);
      add_vec(0, 1, 0, 0, 7'h23, 3'd3, 7'h00, mk(1, 1, 0, 0, 0, 1, 0, 0, A_ADD), 6, 0, 0);
      add_vec(0, 1, 0, 0, 7'h13, 3'd4, 7'h15, mk(1, 1, 0, 1, 0, 0, 0, 0, A_XOR), 7, 0, 0);
      add_vec(0, 1, 0, 0, 7'h33, 3'd6, 7'h00, mk(1, 0, 0, 1, 0, 0, 0, 0, A_OR),  8, 0, 0);
      add_vec(0, 1, 0, 0, 7'h00, 3'd5, 7'h11, mk(1, 0, 0, 0, 0, 0, 0, 0, A_NOP), 9, 0, 0);
      add_vec(0, 1, 0, 0, 7'h33, 3'd1, 7'h00, mk(1, 0, 0, 0, 0, 0, 0, 0, A_NOP), 10, 0, 0);
      add_vec(0, 1, 0, 0, 7'h13, 3'd2, 7'h00, mk(1, 1, 0, 0, 0, 0, 0, 0, A_NOP), 11, 0, 0);
      add_vec(0, 0, 0, 0, 7'h33, 3'd0, 7'h00, BUBBLE,                             11, 0, 0);
      add_vec(0, 1, 1, 1, 7'h33, 3'd0, 7'h00, BUBBLE,                             11, 0, 0);
      add_vec(0, 1, 0, 0, 7'h63, 3'd4, 7'h00, BUBBLE,                             11, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].iv, tbl[i].st, tbl[i].fl, tbl[i].op, tbl[i].f3, tbl[i].f7);
         tick();
         check($sformatf("tbl%0d_bundle", i), 64'(act1), 64'(tbl[i].b));
         check($sformatf("tbl%0d_cnt", i), 64'(issued_cnt), 64'(tbl[i].cnt));
         check($sformatf("tbl%0d_fetch_hold", i), 64'(fetch_hold), 64'(tbl[i].fh));
         check($sformatf("tbl%0d_halted", i), 64'(halted), 64'(tbl[i].h));
      end

      // Default halt: accept at E0, fetch_hold after E0, halted after E3, adds during drain ignored.
      drive(1, 0, 0, 0, 7'h00, 3'd0, 7'h00); tick();
      drive(0, 1, 0, 0, HALT, 3'd0, 7'h00);  tick();
      check("halt_e0_fetch_hold", 64'(fetch_hold), 64'd1);
      check("halt_e0_halted", 64'(halted), 64'd0);
      check("halt_e0_halted_drain0", 64'(halted2), 64'd1);
      drive(0, 1, 0, 0, 7'h33, 3'd0, 7'h00);
      tick();
      check("halt_e1_ex_valid", 64'(ex_valid), 64'd0);
      check("halt_e1_halted", 64'(halted), 64'd0);
      tick();
      check("halt_e2_halted", 64'(halted), 64'd0);
      tick();
      check("halt_e3_halted", 64'(halted), 64'd1);
      check("halt_e3_ex_valid", 64'(ex_valid), 64'd0);
      check("halt_e3_cnt", 64'(issued_cnt), 64'd0);
      tick();
      check("halt_e4_halted", 64'(halted), 64'd1);

      // Reset arriving mid-drain returns everything to its reset state.
      drive(1, 0, 0, 0, 7'h00, 3'd0, 7'h00); tick();
      drive(0, 1, 0, 0, 7'h33, 3'd0, 7'h00); tick();
      drive(0, 1, 0, 0, HALT, 3'd0, 7'h00);  tick();
      drive(0, 1, 0, 0, 7'h33, 3'd0, 7'h00); tick();
      drive(1, 1, 0, 0, 7'h33, 3'd0, 7'h00); tick();
      check("mid_rst_fetch_hold", 64'(fetch_hold), 64'd0);
      check("mid_rst_halted", 64'(halted), 64'd0);
      check("mid_rst_cnt", 64'(issued_cnt), 64'd0);
      check("mid_rst_ex_valid", 64'(ex_valid), 64'd0);
      drive(0, 1, 0, 0, 7'h33, 3'd0, 7'h00); tick();
      check("mid_rst_after_ex_valid", 64'(ex_valid), 64'd1);
      check("mid_rst_after_cnt", 64'(issued_cnt), 64'd1);

      // Unknown opcode 0x73.
      drive(1, 0, 0, 0, 7'h00, 3'd0, 7'h00); tick();
      drive(0, 1, 0, 0, 7'h73, 3'd0, 7'h00); tick();
`ifdef PIPELINE_CTL_ILLEGAL_TRAP_EN
      check("unk_illegal", 64'(illegal), 64'd1);
      check("unk_ex_valid", 64'(ex_valid), 64'd0);
      check("unk_fetch_hold", 64'(fetch_hold), 64'd0);
      drive(0, 1, 0, 0, 7'h33, 3'd0, 7'h00); tick();
      check("unk_next_ex_valid", 64'(ex_valid), 64'd1);
      check("unk_next_illegal", 64'(illegal), 64'd1);
`else
      check("unk_illegal", 64'(illegal), 64'd0);
      check("unk_fetch_hold", 64'(fetch_hold), 64'd1);
      drive(0, 1, 0, 0, 7'h33, 3'd0, 7'h00);
      tick(); tick();
      check("unk_e2_halted", 64'(halted), 64'd0);
      tick();
      check("unk_e3_halted", 64'(halted), 64'd1);
`endif

      // Counter saturation on the 4-bit instance.
      drive(1, 0, 0, 0, 7'h00, 3'd0, 7'h00); tick();
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 0, 0, 7'h33, 3'd0, 7'h00);
         tick();
      end
      check("sat_cnt2", 64'(issued_cnt2), 64'd15);
      check("sat_cnt", 64'(issued_cnt), 64'd16);
      tick();
      check("sat_cnt2_hold", 64'(issued_cnt2), 64'd15);

      // Randomized run against the model.
      drive(1, 0, 0, 0, 7'h00, 3'd0, 7'h00); tick();
      check_all("rnd_reset");
      for (int i = 0; i < 2500; i++) begin
         logic [6:0] op;
         logic [6:0] f7;
         case ($urandom_range(0, 11))
            0, 1:    op = 7'h33;
            2:       op = 7'h13;
            3:       op = 7'h03;
            4:       op = 7'h23;
            5, 6:    op = 7'h63;
            7:       op = 7'h00;
            8:       op = ($urandom_range(0, 3) == 0) ? HALT : 7'h13;
            9:       op = ($urandom_range(0, 3) == 0) ? 7'h73 : 7'h33;
            10:      op = 7'($urandom);
            default: op = 7'h33;
         endcase
         case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom);
         endcase
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
               op, 3'($urandom), f7);
         tick();
         check_all($sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_ctl_seq.md
# pipeline_ctl_seq

Registered, parametrised successor to the combinational pipeline control decoder. It decodes the ID-stage instruction into the ID/EX control bundle and absorbs stall and flush requests by inserting bubbles. It also owns the halt sequence: accept HALT, drain the back-end for a configurable number of cycles, then assert `halted`. It sits between the IF/ID register and the ID/EX register in the 5-stage RISC-V pipeline and replaces direct use of the combinational control outputs.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: cycles spent emitting bubbles after HALT before `halted`; legal range 0..15.
- `CNT_W`, default 32: width of the issued-instruction counter.
- `HALT_OPCODE`, default 7'h7F: opcode recognised as HALT.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `id_valid`  in  1  ID stage holds a real instruction.
- `opcode`  in  7  instruction[6:0].
- `funct3`  in  3  instruction[14:12].
- `funct7`  in  7  instruction[31:25].
- `stall`  in  1  hazard unit load-use stall; inject a bubble this cycle.
- `flush`  in  1  branch taken in EX; kill the ID instruction.
- `ex_valid`  out  1  EX bundle holds a real instruction.
- `alu_src`, `mem_to_reg`, `reg_write`, `mem_read`, `mem_write`, `branch`, `branch_ne`  out  1 each  registered control bits.
- `alu_operation`  out  3  alu module encodings: ADD_64, SUB_64, BIT_AND, BIT_OR, BIT_XOR, ALU_NOP.
- `fetch_hold`  out  1  freeze PC and IF/ID (high in DRAIN and HALTED).
- `halted`  out  1  pipeline drained after HALT.
- `illegal`  out  1  sticky unknown-opcode flag (feature-dependent).
- `issued_cnt`  out  CNT_W  count of non-bubble bundles issued, saturating.

## Operation
- **Accept condition:** `id_valid & ~stall & ~flush & state==RUN`. A non-accepted cycle loads a bubble: all control bits 0, `alu_operation`=ALU_NOP, `ex_valid`=0.
- **R (0110011):** `alu_src`=0, `reg_write`=1.
  - funct3 000: funct7 0x00 → ADD_64; funct7 0x20 → SUB_64.
  - funct3 111/110/100 with funct7 0 → AND/OR/XOR.
  - Any other combination → ALU_NOP with `reg_write`=0.
- **I (0010011):** `alu_src`=1, `reg_write`=1. funct3 000 → ADD_64; 111/110/100 → AND/OR/XOR; otherwise ALU_NOP with `reg_write`=0.
- **LOAD (0000011):** `alu_src`, `mem_to_reg`, `reg_write`, `mem_read` =1; ADD_64.
- **STORE (0100011):** `alu_src`=1, `mem_write`=1; ADD_64; `mem_to_reg`=0 (never X).
- **BRANCH (1100011):** SUB_64. funct3 000 → `branch`=1; funct3 001 → `branch_ne`=1; other funct3 → bubble.
- **Opcode 0:** NOP. `ex_valid`=1, all control bits 0.
- **HALT_OPCODE:** load a bubble and enter DRAIN.
- **State machine:**
  - RUN → DRAIN on accepted HALT (counter loaded with DRAIN_CYCLES).
  - DRAIN decrements the counter each edge; when it reaches 0 → HALTED. With DRAIN_CYCLES=0, go directly RUN → HALTED.
  - HALTED is absorbing until `reset`.
  - In DRAIN and HALTED, all inputs are ignored and only bubbles are issued.
- **Counter:** `issued_cnt` increments by 1 on each edge that loads `ex_valid`=1. It holds at all-ones and never wraps.
- **Reset:** bundle = bubble; `halted`, `fetch_hold`, `illegal` = 0; `issued_cnt`=0; state RUN. Reset wins over every other input, including mid-DRAIN.

## Timing
- Decode-to-output latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- `stall` and `flush` both high → bubble, and the counter does not increment. A HALT arriving under `flush` is discarded.
- `fetch_hold` rises after the acceptance edge of HALT.
- `halted` rises DRAIN_CYCLES edges after the acceptance edge. With default 3: accept at E0, `halted` is visible after E3.
- `illegal` rises 1 cycle after accepting an unknown opcode and stays high until reset.

## Configuration
- Macro `PIPELINE_CTL_ILLEGAL_TRAP_EN`.
- **Defined:** an opcode outside {R, I, LOAD, STORE, BRANCH, 0, HALT_OPCODE} sets sticky `illegal` and is issued as a bubble; execution continues in RUN.
- **Undefined:** any unknown opcode is treated exactly as HALT (legacy behaviour), and `illegal` is tied to 0.

## Test plan
- **Reset then decode:** reset, then `add` (funct3 0, funct7 0) → next cycle `reg_write`=1, ADD_64, `ex_valid`=1, `issued_cnt`=1.
- **Stall/flush priority:** `sub` with `stall`=1 → bubble and `issued_cnt` unchanged. `flush` together with HALT_OPCODE → no DRAIN; `fetch_hold` stays 0.
- **BNE:** opcode 1100011, funct3 001 → `branch_ne`=1, `branch`=0, SUB_64.
- **Default halt:** HALT at E0 → `fetch_hold`=1 after E0, `halted`=1 after E3. Issuing `add` during DRAIN produces bubbles only.
- **Reset mid-drain:** reset asserted at E2 of DRAIN → state RUN, `halted`=0, `fetch_hold`=0, `issued_cnt`=0.
- **Unknown opcode 7'h33 | 7'h40 (0x73):**
  - Macro defined → `illegal`=1, bubble, still in RUN.
  - Macro undefined → DRAIN, `halted` after DRAIN_CYCLES. Also run CNT_W=4 with 16 `add`s → `issued_cnt` holds at 15.
